fp_addsub_pipe: RTL and testbench
=================================

Name: fp_addsub_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor.
- Successor to the combinational half-precision adder. Adds generic exponent/mantissa widths, valid/ready flow control, selectable rounding, special-value handling and exception flags.
- Sits between operand-issue logic and the result writeback/consumer in the FP datapath.

Parameters:
- EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 10, stored mantissa (fraction) width, implicit 1 not stored.
- W, 1+EXP_W+MAN_W (derived, not overridable), packed operand width {sign, exponent, fraction}.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- in_add  in  1  1 = a+b, 0 = a-b (b sign inverted).
- in_rnd  in  1  0 = round-to-nearest-even, 1 = truncate (toward zero).
- in_a  in  W  operand A, packed.
- in_b  in  W  operand B, packed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  W  packed result.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset: all stage valid bits, out_valid, out_result and out_flags clear to 0. in_ready = 1 in the first cycle after reset release.
  - Reset asserted mid-operation discards all in-flight operations; no partial result is emitted.
- Pipeline advance: advance = !out_valid | out_ready. in_ready = advance.
  - Transfer occurs on in_valid & in_ready.
  - When advance = 0, all stages hold their contents and bubbles are not collapsed.
  - Latency is exactly 3 cycles from accept to out_valid, with no back-pressure.
  - Throughput is 1 result per cycle.
- out_result and out_flags are stable while out_valid & !out_ready.
- S1, unpack/align:
  - Effective sign of B = b.sign XOR !in_add.
  - Exponent field 0 is treated as zero (denormal inputs flush to zero).
  - Exponent field all-ones is Inf (fraction 0) or NaN (fraction != 0).
  - Larger-magnitude operand is selected by {exp, frac} compare; equal magnitude picks A.
  - Smaller significand {1, frac} is right-shifted by the exponent difference into MAN_W+4 bits: guard, round, sticky.
  - Sticky is the OR of all bits shifted past. A shift >= MAN_W+3 leaves only sticky.
- S2, add:
  - Same effective signs: add significands. Different signs: subtract smaller from larger (result is never negative).
  - Result sign = sign of the larger operand.
- S3, normalise/round:
  - Carry out: shift right 1 (sticky keeps the shifted bit), exponent +1.
  - Otherwise: left-shift by leading-zero count, exponent decremented by the same amount.
  - RNE rounds up if G & (R | S | LSB). Truncate never rounds up.
  - A rounding carry renormalises and exponent +1.
  - inexact = G|R|S before rounding.
- Special cases (priority order):
  - Any NaN input, or Inf − Inf (effective): result is canonical qNaN {0, all-ones, 1 followed by zeros}; invalid = 1; other flags 0.
  - Any Inf input: that Inf with its effective sign; flags 0.
  - Exact zero result: +0, except (−0)+(−0) which gives −0; flags 0.
  - Rounded exponent >= all-ones: overflow = inexact = 1. Result is ±Inf under RNE, ±max-finite under truncate.
  - Final exponent < 1: result is ±0 (flush); underflow = inexact = 1.
- Flag and result bits are registered together with out_valid.

Test Plan (EXP_W=5, MAN_W=10):
- 0x3C00 + 0x3C00, add=1, RNE -> 0x4000 after 3 cycles, flags 0. Then 0x3C00 − 0x3C00 -> 0x0000, flags 0.
- 0x3C01 + 0x1000 (tie) -> RNE 0x3C02 with inexact; truncate 0x3C01 with inexact.
- 0x7BFF + 0x7BFF -> RNE 0x7C00, flags {0,1,0,1}; truncate 0x7BFF, same flags.
- 0x7C00 − 0x7C00 -> 0x7E00, invalid = 1.
- 0x0400 − 0x03FF (denormal B flushed) -> 0x0400, flags 0. Then 0x0401 − 0x0400 -> 0x0000 with underflow and inexact.
- Back-pressure stream of 8 back-to-back ops with out_ready low for 5 cycles mid-stream:
  - in_ready drops in the same cycle out_ready is low while out_valid.
  - All 8 results arrive in order, none lost or duplicated.
  - rst_n pulsed mid-stream -> out_valid 0 next cycle and no stale results afterwards.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Stages: S1 unpack/align, S2 significand add/subtract, S3 normalise/round/pack.
module fp_addsub_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_add,
   input  logic         in_rnd,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_result,
   output logic [3:0]   out_flags
);

   localparam int AW  = MAN_W + 4;
   localparam int SW  = MAN_W + 1;
   localparam int LZW = $clog2(AW + 1);
   localparam int XW  = EXP_W + LZW + 2;
   localparam logic [EXP_W-1:0] EMAX  = '1;
   localparam logic [MAN_W-1:0] QFRAC = MAN_W'(1) << (MAN_W - 1);

   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // ---------------- S1: unpack / align ----------------
   logic             sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic [W-2:0]     mag_a, mag_b;
   logic [SW-1:0]    sig_a, sig_b;

   assign sa    = in_a[W-1];
   assign ea    = in_a[W-2:MAN_W];
   assign fa    = in_a[MAN_W-1:0];
   assign sb    = in_b[W-1] ^ ~in_add;
   assign eb    = in_b[W-2:MAN_W];
   assign fb    = in_b[MAN_W-1:0];
   assign za    = (ea == '0);
   assign zb    = (eb == '0);
   assign nan_a = (&ea) & (|fa);
   assign nan_b = (&eb) & (|fb);
   assign inf_a = (&ea) & ~(|fa);
   assign inf_b = (&eb) & ~(|fb);
   // denormal inputs flush to zero, so their fraction must not affect the compare
   assign mag_a = za ? '0 : {ea, fa};
   assign mag_b = zb ? '0 : {eb, fb};
   assign sig_a = za ? '0 : {1'b1, fa};
   assign sig_b = zb ? '0 : {1'b1, fb};

   logic             sl, ss;
   logic [EXP_W-1:0] el, es, d;
   logic [SW-1:0]    sig_l, sig_s;
   logic [31:0]      sh;
   logic [2*AW-1:0]  wide;
   logic [AW-1:0]    al_big, al_small;

   always_comb begin
      if (mag_a >= mag_b) begin
         sl = sa; el = ea; sig_l = sig_a;
         ss = sb; es = eb; sig_s = sig_b;
      end else begin
         sl = sb; el = eb; sig_l = sig_b;
         ss = sa; es = ea; sig_s = sig_a;
      end
      d  = el - es;
      sh = (32'(d) > 32'(AW)) ? 32'(AW) : 32'(d);
      // lower half collects everything shifted past the sticky position
      wide     = {sig_s, 3'b000, {AW{1'b0}}} >> sh;
      al_small = wide[2*AW-1:AW] | {{(AW-1){1'b0}}, |wide[AW-1:0]};
      al_big   = {sig_l, 3'b000};
   end

   logic             s1_valid, s1_sign, s1_sub, s1_rnd, s1_nan, s1_inf, s1_inf_sign, s1_zneg;
   logic [EXP_W-1:0] s1_exp;
   logic [AW-1:0]    s1_big, s1_small;

   // ---------------- S2: add / subtract ----------------
   logic             s2_valid, s2_sign, s2_rnd, s2_nan, s2_inf, s2_inf_sign, s2_zneg;
   logic [EXP_W-1:0] s2_exp;
   logic [AW:0]      s2_sum, sum_c;

   assign sum_c = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                         : ({1'b0, s1_big} + {1'b0, s1_small});

   // ---------------- S3: normalise / round / pack ----------------
   logic                carry, g, r, s, lsb, inexact, rnd_up;
   logic [LZW-1:0]      lzc;
   logic [AW-1:0]       m;
   logic signed [XW-1:0] exp_n, exp_r;
   logic [SW:0]         mant_r;
   logic [MAN_W-1:0]    frac;
   logic [W-1:0]        res_c;
   logic [3:0]          flags_c;

   always_comb begin
      lzc = LZW'(AW);
      for (int i = 0; i < AW; i++) begin
         if (s2_sum[i]) lzc = LZW'(AW - 1 - i);
      end
      carry = s2_sum[AW];
      if (carry) begin
         m     = s2_sum[AW:1] | {{(AW-1){1'b0}}, s2_sum[0]};
         exp_n = XW'(s2_exp) + XW'(1);
      end else begin
         m     = s2_sum[AW-1:0] << lzc;
         exp_n = XW'(s2_exp) - XW'(lzc);
      end
      lsb     = m[3];
      g       = m[2];
      r       = m[1];
      s       = m[0];
      inexact = g | r | s;
      rnd_up  = ~s2_rnd & g & (r | s | lsb);
      mant_r  = {1'b0, m[AW-1:3]} + (SW+1)'(rnd_up);
      if (mant_r[SW]) begin
         frac  = mant_r[MAN_W:1];
         exp_r = exp_n + XW'(1);
      end else begin
         frac  = mant_r[MAN_W-1:0];
         exp_r = exp_n;
      end

      res_c   = {s2_sign, exp_r[EXP_W-1:0], frac};
      flags_c = {3'b000, inexact};
      if (s2_nan) begin
         res_c   = {1'b0, EMAX, QFRAC};
         flags_c = 4'b1000;
      end else if (s2_inf) begin
         res_c   = {s2_inf_sign, EMAX, {MAN_W{1'b0}}};
         flags_c = 4'b0000;
      end else if (s2_sum == '0) begin
         res_c   = {s2_zneg, {(W-1){1'b0}}};
         flags_c = 4'b0000;
      end else if (exp_r >= $signed(XW'(EMAX))) begin
         res_c   = s2_rnd ? {s2_sign, EMAX - EXP_W'(1), {MAN_W{1'b1}}}
                          : {s2_sign, EMAX, {MAN_W{1'b0}}};
         flags_c = 4'b0101;
      end else if (exp_r < $signed(XW'(1))) begin
         res_c   = {s2_sign, {(W-1){1'b0}}};
         flags_c = 4'b0011;
      end
   end

   // ---------------- control (valids and outputs, reset) ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         if (s2_valid) begin
            out_result <= res_c;
            out_flags  <= flags_c;
         end
      end
   end

   // ---------------- datapath registers (no reset needed) ----------------
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_sign     <= sl;
         s1_sub      <= sl ^ ss;
         s1_rnd      <= in_rnd;
         s1_exp      <= el;
         s1_big      <= al_big;
         s1_small    <= al_small;
         s1_nan      <= nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
         s1_inf      <= inf_a | inf_b;
         s1_inf_sign <= inf_a ? sa : sb;
         s1_zneg     <= za & zb & sa & sb;

         s2_sign     <= s1_sign;
         s2_rnd      <= s1_rnd;
         s2_exp      <= s1_exp;
         s2_sum      <= sum_c;
         s2_nan      <= s1_nan;
         s2_inf      <= s1_inf;
         s2_inf_sign <= s1_inf_sign;
         s2_zneg     <= s1_zneg;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe (half precision: EXP_W=5, MAN_W=10).
module tb_fp_addsub_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_add, in_rnd;
   logic [15:0] in_a, in_b;
   logic        out_valid, out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_flags;

   int passed = 0;
   int total  = 0;

   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_add(in_add), .in_rnd(in_rnd),
      .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   // drive one operation and wait (bounded) for its result; lat = cycles to out_valid
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic add,
                         input logic rnd, output logic [15:0] res, output logic [3:0] fl,
                         output int lat);
      @(negedge clk);
      in_a = a; in_b = b; in_add = add; in_rnd = rnd; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      res = out_result;
      fl  = out_flags;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_add = 1'b1; in_rnd = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
      else passed++;
      total++;
      if (out_result !== 16'h0000) $display("FAIL reset_out_result got %h want 0000", out_result);
      else passed++;
      total++;
      if (out_flags !== 4'b0000) $display("FAIL reset_out_flags got %b want 0000", out_flags);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
      else passed++;
   endtask

   task automatic test_basic();
      logic [15:0] res; logic [3:0] fl; int lat;
      run_op(16'h3C00, 16'h3C00, 1'b1, 1'b0, res, fl, lat);
      total++;
      if (lat !== 3) $display("FAIL basic_latency got %0d want 3", lat);
      else passed++;
      total++;
      if (res !== 16'h4000) $display("FAIL basic_add got %h want 4000", res);
      else passed++;
      total++;
      if (fl !== 4'b0000) $display("FAIL basic_add_flags got %b want 0000", fl);
      else passed++;
      run_op(16'h3C00, 16'h3C00, 1'b0, 1'b0, res, fl, lat);
      total++;
      if (res !== 16'h0000) $display("FAIL basic_sub_zero got %h want 0000", res);
      else passed++;
      total++;
      if (fl !== 4'b0000) $display("FAIL basic_sub_flags got %b want 0000", fl);
      else passed++;
   endtask

   task automatic test_rounding();
      logic [15:0] res; logic [3:0] fl; int lat;
      run_op(16'h3C01, 16'h1000, 1'b1, 1'b0, res, fl, lat);
      total++;
      if (res !== 16'h3C02) $display("FAIL round_rne got %h want 3C02", res);
      else passed++;
      total++;
      if (fl !== 4'b0001) $display("FAIL round_rne_flags got %b want 0001", fl);
      else passed++;
      run_op(16'h3C01, 16'h1000, 1'b1, 1'b1, res, fl, lat);
      total++;
      if (res !== 16'h3C01) $display("FAIL round_trunc got %h want 3C01", res);
      else passed++;
      total++;
      if (fl !== 4'b0001) $display("FAIL round_trunc_flags got %b want 0001", fl);
      else passed++;
   endtask

   task automatic test_overflow();
      logic [15:0] res; logic [3:0] fl; int lat;
      run_op(16'h7BFF, 16'h7BFF, 1'b1, 1'b0, res, fl, lat);
      total++;
      if (res !== 16'h7C00) $display("FAIL ovf_rne got %h want 7C00", res);
      else passed++;
      total++;
      if (fl !== 4'b0101) $display("FAIL ovf_rne_flags got %b want 0101", fl);
      else passed++;
      run_op(16'h7BFF, 16'h7BFF, 1'b1, 1'b1, res, fl, lat);
      total++;
      if (res !== 16'h7BFF) $display("FAIL ovf_trunc got %h want 7BFF", res);
      else passed++;
      total++;
      if (fl !== 4'b0101) $display("FAIL ovf_trunc_flags got %b want 0101", fl);
      else passed++;
   endtask

   task automatic test_invalid();
      logic [15:0] res; logic [3:0] fl; int lat;
      run_op(16'h7C00, 16'h7C00, 1'b0, 1'b0, res, fl, lat);
      total++;
      if (res !== 16'h7E00) $display("FAIL inf_minus_inf got %h want 7E00", res);
      else passed++;
      total++;
      if (fl !== 4'b1000) $display("FAIL inf_minus_inf_flags got %b want 1000", fl);
      else passed++;
   endtask

   task automatic test_flush();
      logic [15:0] res; logic [3:0] fl; int lat;
      run_op(16'h0400, 16'h03FF, 1'b0, 1'b0, res, fl, lat);
      total++;
      if (res !== 16'h0400) $display("FAIL denorm_flush got %h want 0400", res);
      else passed++;
      total++;
      if (fl !== 4'b0000) $display("FAIL denorm_flush_flags got %b want 0000", fl);
      else passed++;
      run_op(16'h0401, 16'h0400, 1'b0, 1'b0, res, fl, lat);
      total++;
      if (res !== 16'h0000) $display("FAIL underflow got %h want 0000", res);
      else passed++;
      total++;
      if (fl !== 4'b0011) $display("FAIL underflow_flags got %b want 0011", fl);
      else passed++;
   endtask

   task automatic test_back_to_back();
      // operand A = 1..8, B = 1.0 : results 2..9
      logic [15:0] va[8]  = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                              16'h4500, 16'h4600, 16'h4700, 16'h4800};
      logic [15:0] exp[8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500,
                              16'h4600, 16'h4700, 16'h4800, 16'h4880};
      logic [15:0] got[8];
      logic [15:0] held;
      logic        held_v;
      int sent, rcv, drop_seen, drop_bad, stable_bad;
      sent = 0; rcv = 0; drop_seen = 0; drop_bad = 0; stable_bad = 0; held_v = 1'b0; held = '0;
      for (int i = 0; i < 8; i++) got[i] = 16'hDEAD;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 5 && cyc < 10);
         in_valid  = (sent < 8);
         in_a      = va[(sent < 8) ? sent : 0];
         in_b      = 16'h3C00; in_add = 1'b1; in_rnd = 1'b0;
         #1;
         if (out_valid && !out_ready) begin
            drop_seen++;
            if (in_ready) drop_bad++;
            if (held_v && out_result !== held) stable_bad++;
            held = out_result; held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            if (rcv < 8) got[rcv] = out_result;
            rcv++;
         end
         if (in_valid && in_ready) sent++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      total++;
      if (drop_seen !== 5 || drop_bad !== 0)
         $display("FAIL bp_in_ready stalls=%0d ready_high=%0d want 5 and 0", drop_seen, drop_bad);
      else passed++;
      total++;
      if (stable_bad !== 0) $display("FAIL bp_stable changes=%0d want 0", stable_bad);
      else passed++;
      total++;
      if (rcv !== 8) $display("FAIL bp_count got %0d want 8", rcv);
      else passed++;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (got[i] !== exp[i]) $display("FAIL bp_result[%0d] got %h want %h", i, got[i], exp[i]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_stream();
      logic [15:0] res; logic [3:0] fl; int lat, stale;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_a = 16'h4400; in_b = 16'h3C00; in_add = 1'b1; in_rnd = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid);
      else passed++;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      total++;
      if (stale !== 0) $display("FAIL midrst_stale got %0d want 0", stale);
      else passed++;
      run_op(16'h4000, 16'h3C00, 1'b0, 1'b0, res, fl, lat);
      total++;
      if (res !== 16'h3C00 || lat !== 3)
         $display("FAIL midrst_recover got %h lat %0d want 3C00 lat 3", res, lat);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_overflow();
      test_invalid();
      test_flush();
      test_back_to_back();
      test_reset_mid_stream();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
